da_converter_pio_out_mc: RTL

//  Multi-channel Avalon-MM output PIO for the da_converter system; next generation of the single 8-bit HEX port.

---
 rtl/da_converter_pio_out_mc.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/da_converter_pio_out_mc.sv
// -----------------------------------------------------------------------------
// da_converter_pio_out_mc
//   Multi-channel Avalon-MM output PIO. Drives CH channels of WIDTH bits each
//   (one 7-seg digit or DAC word per channel). It supports per-channel blink,
//   a global blank and output inversion for active-low displays. The read path
//   is registered.
//
//   Optional feature macro: DA_PIO_SHADOW_UPDATE_EN
//     When defined, DATA writes land in shadow registers. Writing CTRL with
//     bit2 (COMMIT) set copies every shadow into the active DATA registers.
//     When undefined, DATA writes go straight to the active registers.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   address      Avalon word address (ADDR_W bits)
//   chipselect   slave select
//   write_n      active-low write strobe
//   read_n       active-low read strobe
//   writedata    32-bit write data
//   readdata     32-bit read data, fixed read latency 1
//   out_port     CH*WIDTH outputs, channel i on out_port[i*WIDTH +: WIDTH]
//   blink_phase  current blink phase
//
// Register map (word addresses)
//   0..CH-1  DATA[i]     [WIDTH-1:0]
//   CH       BLINK_MASK  [CH-1:0]
//   CH+1     PERIOD      [PRESC_W-1:0]
//   CH+2     CTRL        bit0 BLANK, bit1 INVERT, bit2 COMMIT (write-only)
// -----------------------------------------------------------------------------
module da_converter_pio_out_mc #(
   parameter int               CH          = 6,
   parameter int               WIDTH       = 8,
   parameter int               PRESC_W     = 24,
   parameter int               ADDR_W      = 5,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic                read_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   output logic [CH*WIDTH-1:0] out_port,
   output logic                blink_phase
);

   localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(CH);
   localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(CH + 1);
   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(CH + 2);

   // Bus semantics: there is no waitrequest. A write is accepted on every edge
   // where chipselect & ~write_n is high. A read is accepted on every edge where
   // chipselect & ~read_n is high, and readdata is valid from that edge on.
   // readdata holds its value until the next accepted read.
   logic w_wr;
   logic w_rd;
   assign w_wr = chipselect & ~write_n;
   assign w_rd = chipselect & ~read_n;

   logic [WIDTH-1:0]   r_data [CH];
   logic [CH-1:0]      r_mask;
   logic [PRESC_W-1:0] r_period;
   logic [PRESC_W-1:0] r_cnt;
   logic               r_phase;
   logic               r_blank;
   logic               r_invert;
   logic [31:0]        r_rdata;
   logic [CH*WIDTH-1:0] r_out;

   logic w_period_wr;
   assign w_period_wr = w_wr & (address == A_PERIOD);

   // Upper writedata bits are don't-care for every register.
   logic w_unused;
   assign w_unused = &{1'b0, writedata};

`ifdef DA_PIO_SHADOW_UPDATE_EN
   logic [WIDTH-1:0] r_shadow [CH];
   logic             w_commit;
   assign w_commit = w_wr & (address == A_CTRL) & writedata[2];

   // The commit copies the shadow value from before this edge. A DATA write
   // on the same edge only updates the shadow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CH; i++) begin
            r_shadow[i] <= RESET_VALUE;
            r_data[i]   <= RESET_VALUE;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (w_wr && address == ADDR_W'(i)) r_shadow[i] <= writedata[WIDTH-1:0];
            if (w_commit)                      r_data[i]   <= r_shadow[i];
         end
      end
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CH; i++) r_data[i] <= RESET_VALUE;
      end else begin
         for (int i = 0; i < CH; i++)
            if (w_wr && address == ADDR_W'(i)) r_data[i] <= writedata[WIDTH-1:0];
      end
   end
`endif

   // Control registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mask   <= '0;
         r_period <= '0;
         r_blank  <= 1'b0;
         r_invert <= 1'b0;
      end else if (w_wr) begin
         if (address == A_MASK)   r_mask   <= writedata[CH-1:0];
         if (address == A_PERIOD) r_period <= writedata[PRESC_W-1:0];
         if (address == A_CTRL) begin
            r_blank  <= writedata[0];
            r_invert <= writedata[1];
         end
      end
   end

   // Blink prescaler. A PERIOD write restarts the blink cycle and takes
   // priority over a terminal count on the same edge. PERIOD==0 parks the
   // counter and the phase at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (w_period_wr || r_period == '0) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (r_cnt == r_period) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt <= r_cnt + PRESC_W'(1);
      end
   end

   // Read mux. DATA reads return the value software last wrote, which is the
   // shadow when the shadow feature is built.
   logic [31:0] w_rdata;
   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < CH; i++) begin
         if (address == ADDR_W'(i)) begin
`ifdef DA_PIO_SHADOW_UPDATE_EN
            w_rdata[WIDTH-1:0] = r_shadow[i];
`else
            w_rdata[WIDTH-1:0] = r_data[i];
`endif
         end
      end
      if (address == A_MASK)   w_rdata[CH-1:0]      = r_mask;
      if (address == A_PERIOD) w_rdata[PRESC_W-1:0] = r_period;
      if (address == A_CTRL)   w_rdata[1:0]         = {r_invert, r_blank};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     r_rdata <= '0;
      else if (w_rd) r_rdata <= w_rdata;
   end

   // Output stage. A blanked channel shows the inactive level, which is
   // all-ones when INVERT is set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out <= {CH{RESET_VALUE}};
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (r_blank | (r_mask[i] & r_phase))
               r_out[i*WIDTH +: WIDTH] <= {WIDTH{r_invert}};
            else
               r_out[i*WIDTH +: WIDTH] <= r_data[i] ^ {WIDTH{r_invert}};
         end
      end
   end

   assign readdata    = r_rdata;
   assign out_port    = r_out;
   assign blink_phase = r_phase;

endmodule
